// File: rtl/ser_digit_addsub_if.sv
// Digit-serial add/subtract bus: operand digits in, result digit and word flags out.
interface ser_digit_addsub_if #(
    parameter int DW = 1
);
    logic          i_start;
    logic          i_sub;
    logic          i_en;
    logic [DW-1:0] i_a;
    logic [DW-1:0] i_b;
    logic [DW-1:0] o_q;
    logic          o_v;
    logic          o_busy;
    logic          o_done;
    logic          o_ovf;
    logic          o_zero;

    modport master (
        output i_start, i_sub, i_en, i_a, i_b,
        input  o_q, o_v, o_busy, o_done, o_ovf, o_zero
    );

    modport slave (
        input  i_start, i_sub, i_en, i_a, i_b,
        output o_q, o_v, o_busy, o_done, o_ovf, o_zero
    );
endinterface

// File: rtl/ser_digit_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first,
// one result digit per accepted input digit.
module ser_digit_addsub #(
    parameter int DW   = 1,
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic rst,
    ser_digit_addsub_if.slave bus
);
    localparam int N  = XLEN / DW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sub;
    logic          r_zacc;
    logic [DW-1:0] r_q;
    logic          r_v;
    logic          r_done;
    logic          r_ovf;
    logic          r_zero;

    logic          w_acc;
    logic          w_sub;
    logic          w_cin;
    logic [DW-1:0] w_b;
    logic [DW:0]   w_sum;
    logic          w_c_msb;
    logic          w_last;
    logic          w_zero;

    assign w_acc = bus.i_en & (bus.i_start | (r_state == RUN));
    assign w_sub = bus.i_start ? bus.i_sub : r_sub;
    assign w_cin = bus.i_start ? bus.i_sub : r_v;
    assign w_b   = w_sub ? ~bus.i_b : bus.i_b;
    assign w_sum = {1'b0, bus.i_a} + {1'b0, w_b} + {{DW{1'b0}}, w_cin};

    // Carry into the top bit recovered from the top-bit sum: a ^ b ^ s.
    assign w_c_msb = bus.i_a[DW-1] ^ w_b[DW-1] ^ w_sum[DW-1];

    // A start digit always begins a new word, even if it lands on cnt = N-1.
    assign w_last = bus.i_start ? (N == 1) : (r_cnt == LAST);
    assign w_zero = (bus.i_start | r_zacc) & ~|w_sum[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sub   <= 1'b0;
            r_zacc  <= 1'b0;
            r_q     <= '0;
            r_v     <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_acc) begin
                r_q    <= w_sum[DW-1:0];
                r_v    <= w_sum[DW];
                r_zacc <= w_zero;
                if (bus.i_start) begin
                    r_sub <= bus.i_sub;
                end
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b1;
                    r_ovf   <= w_c_msb ^ w_sum[DW];
                    r_zero  <= w_zero;
                end else begin
                    r_state <= RUN;
                    r_cnt   <= bus.i_start ? CW'(1) : r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_q    = r_q;
    assign bus.o_v    = r_v;
    assign bus.o_busy = (r_state == RUN);
    assign bus.o_done = r_done;
    assign bus.o_ovf  = r_ovf;
    assign bus.o_zero = r_zero;
endmodule

// File: tb/tb_ser_digit_addsub.sv
// Directed bench: bit-serial 8-bit instance and nibble-serial 32-bit instance
// driven from one clock, expected values worked out by hand.
module tb_ser_digit_addsub;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ser_digit_addsub_if #(.DW(1)) b8 ();
    ser_digit_addsub_if #(.DW(4)) b32 ();

    ser_digit_addsub #(.DW(1), .XLEN(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    ser_digit_addsub #(.DW(4), .XLEN(32)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv8(input logic st, input logic sub, input logic en,
                        input logic a, input logic b);
        b8.i_start = st;
        b8.i_sub   = sub;
        b8.i_en    = en;
        b8.i_a     = a;
        b8.i_b     = b;
    endtask

    // One full 8-digit word on the DW=1 instance; o_done only after digit 7.
    task automatic word8(input string tag, input logic sub,
                         input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q);
        for (int i = 0; i < 8; i++) begin
            drv8(i == 0, sub, 1'b1, a[i], b[i]);
            tick();
            q[i] = b8.o_q[0];
            chk({tag, "_done"}, {31'd0, b8.o_done}, {31'd0, i == 7});
        end
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [7:0]  q8;
    logic [31:0] q32;
    logic [7:0]  ta;
    logic [7:0]  tb;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        b32.i_start = 1'b0;
        b32.i_sub   = 1'b0;
        b32.i_en    = 1'b0;
        b32.i_a     = '0;
        b32.i_b     = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_q",    {31'd0, b8.o_q},    32'd0);
        chk("rst_v",    {31'd0, b8.o_v},    32'd0);
        chk("rst_busy", {31'd0, b8.o_busy}, 32'd0);
        chk("rst_done", {31'd0, b8.o_done}, 32'd0);
        chk("rst_ovf",  {31'd0, b8.o_ovf},  32'd0);
        chk("rst_zero", {31'd0, b8.o_zero}, 32'd0);
        chk("rst_q32",  {28'd0, b32.o_q},   32'd0);

        // 0x05 + 0x03 = 0x08
        word8("add", 1'b0, 8'h05, 8'h03, q8);
        chk("add_q",    {24'd0, q8},        32'h08);
        chk("add_ovf",  {31'd0, b8.o_ovf},  32'd0);
        chk("add_zero", {31'd0, b8.o_zero}, 32'd0);
        chk("add_v",    {31'd0, b8.o_v},    32'd0);
        tick();
        chk("add_done_clr", {31'd0, b8.o_done}, 32'd0);
        chk("add_idle",     {31'd0, b8.o_busy}, 32'd0);

        // 0x80 - 0x01 = 0x7F, signed overflow
        word8("sub1", 1'b1, 8'h80, 8'h01, q8);
        chk("sub1_q",    {24'd0, q8},        32'h7F);
        chk("sub1_ovf",  {31'd0, b8.o_ovf},  32'd1);
        chk("sub1_zero", {31'd0, b8.o_zero}, 32'd0);
        chk("sub1_v",    {31'd0, b8.o_v},    32'd1);

        // 0x2A - 0x2A = 0, zero with final carry
        word8("sub2", 1'b1, 8'h2A, 8'h2A, q8);
        chk("sub2_q",    {24'd0, q8},        32'h00);
        chk("sub2_ovf",  {31'd0, b8.o_ovf},  32'd0);
        chk("sub2_zero", {31'd0, b8.o_zero}, 32'd1);
        chk("sub2_v",    {31'd0, b8.o_v},    32'd1);

        // Idle digit without start is ignored
        drv8(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("idle_q",    {31'd0, b8.o_q},    32'd0);
        chk("idle_v",    {31'd0, b8.o_v},    32'd1);
        chk("idle_busy", {31'd0, b8.o_busy}, 32'd0);
        chk("idle_done", {31'd0, b8.o_done}, 32'd0);

        // Stall: 0x0F + 0x01 = 0x10, 3 idle cycles after the third digit
        ta = 8'h0F;
        tb = 8'h01;
        for (int i = 0; i < 3; i++) begin
            drv8(i == 0, 1'b0, 1'b1, ta[i], tb[i]);
            tick();
            q8[i] = b8.o_q[0];
            if (i == 0) begin
                chk("stl_zero_hold", {31'd0, b8.o_zero}, 32'd1);
                chk("stl_busy",      {31'd0, b8.o_busy}, 32'd1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drv8(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick();
            chk("stl_q_hold", {31'd0, b8.o_q},    32'd0);
            chk("stl_v_hold", {31'd0, b8.o_v},    32'd1);
            chk("stl_done",   {31'd0, b8.o_done}, 32'd0);
        end
        for (int i = 3; i < 8; i++) begin
            drv8(1'b0, 1'b0, 1'b1, ta[i], tb[i]);
            tick();
            q8[i] = b8.o_q[0];
            chk("stl_done_seq", {31'd0, b8.o_done}, {31'd0, i == 7});
        end
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stl_q",    {24'd0, q8},        32'h10);
        chk("stl_zero", {31'd0, b8.o_zero}, 32'd0);
        chk("stl_ovf",  {31'd0, b8.o_ovf},  32'd0);

        // Restart: 0x11+0x22 aborted after 4 digits, then 0x7F + 0x01
        ta = 8'h11;
        tb = 8'h22;
        for (int i = 0; i < 4; i++) begin
            drv8(i == 0, 1'b0, 1'b1, ta[i], tb[i]);
            tick();
            chk("rs_abort_done", {31'd0, b8.o_done}, 32'd0);
        end
        word8("rs", 1'b0, 8'h7F, 8'h01, q8);
        chk("rs_q",    {24'd0, q8},        32'h80);
        chk("rs_ovf",  {31'd0, b8.o_ovf},  32'd1);
        chk("rs_zero", {31'd0, b8.o_zero}, 32'd0);

        // Reset mid-word, with start/en asserted on the reset edge
        ta = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            drv8(i == 0, 1'b0, 1'b1, ta[i], ta[i]);
            tick();
        end
        chk("mr_busy_pre", {31'd0, b8.o_busy}, 32'd1);
        rst = 1'b1;
        drv8(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        chk("mr_q",    {31'd0, b8.o_q},    32'd0);
        chk("mr_v",    {31'd0, b8.o_v},    32'd0);
        chk("mr_busy", {31'd0, b8.o_busy}, 32'd0);
        chk("mr_done", {31'd0, b8.o_done}, 32'd0);
        chk("mr_ovf",  {31'd0, b8.o_ovf},  32'd0);
        chk("mr_zero", {31'd0, b8.o_zero}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drv8(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            tick();
            chk("mr_no_done", {31'd0, b8.o_done}, 32'd0);
        end
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // DW=4: 0x7FFFFFFF + 0x00000001 = 0x80000000
        for (int i = 0; i < 8; i++) begin
            b32.i_start = (i == 0);
            b32.i_sub   = 1'b0;
            b32.i_en    = 1'b1;
            b32.i_a     = (i == 7) ? 4'h7 : 4'hF;
            b32.i_b     = (i == 0) ? 4'h1 : 4'h0;
            tick();
            q32[i*4 +: 4] = b32.o_q;
            chk("w32_done", {31'd0, b32.o_done}, {31'd0, i == 7});
        end
        b32.i_en = 1'b0;
        chk("w32_q",    q32,                 32'h80000000);
        chk("w32_ovf",  {31'd0, b32.o_ovf},  32'd1);
        chk("w32_zero", {31'd0, b32.o_zero}, 32'd0);
        chk("w32_v",    {31'd0, b32.o_v},    32'd0);
        tick();
        chk("w32_done_clr", {31'd0, b32.o_done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
